// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, exec FSM states and default width
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // Op-select encoding shared with the opcode decoder
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_MUL = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - iterative unsigned shift-add multiplier datapath
module seq_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Accumulator value after the current step; on the final step this is the full product
  always_comb begin
    product = acc;
    if (mplier[0]) begin
      product = acc + mcand;
    end
  end

  assign last = step && (cnt == CNT_W'(1));

  // Load operands on acceptance, then one add-and-shift per active step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
    end else if (step && (cnt != '0)) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - ALU execution unit: single-cycle ADD/AND/OR, iterative MUL
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  alu_state_e         state_q;
  alu_state_e         state_d;
  logic               accept;
  logic               mul_load;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   logic_res;

  // A request is taken whenever no multiply is iterating
  assign accept   = start && (state_q != MUL);
  assign mul_load = accept && (signal == ALU_MUL);
  assign busy     = (state_q == MUL);
  assign done     = (state_q == DONE);
  assign sum      = {1'b0, a} + {1'b0, b};

  seq_shift_add_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .a      (a),
    .b      (b),
    .step   (busy),
    .product(mul_product),
    .last   (mul_last)
  );

  // Single-cycle op result selection
  always_comb begin
    logic_res = sum[WIDTH-1:0];
    case (signal)
      ALU_AND: logic_res = a & b;
      ALU_OR:  logic_res = a | b;
      default: logic_res = sum[WIDTH-1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept from IDLE/DONE, multiply runs until its last step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (signal == ALU_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = (signal == ALU_MUL) ? MUL : DONE;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result and flag registers, updated only when an op completes
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
    end else if (accept && (signal != ALU_MUL)) begin
      result    <= logic_res;
      result_hi <= '0;
      carry     <= (signal == ALU_ADD) ? sum[WIDTH] : 1'b0;
      zero      <= (logic_res == '0);
    end else if (mul_last) begin
      result    <= mul_product[WIDTH-1:0];
      result_hi <= mul_product[2*WIDTH-1:WIDTH];
      carry     <= 1'b0;
      zero      <= (mul_product[WIDTH-1:0] == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  signal;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        carry;
  logic        zero;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  alu_seq_exec dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signal   (signal),
    .a        (a),
    .b        (b),
    .result   (result),
    .result_hi(result_hi),
    .carry    (carry),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                         input logic exp_zero);
    int cycles;
    start = 1'b1; signal = 2'b01; a = x; b = y;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      if (cycles == 2) begin
        start = 1'b1; signal = 2'b10;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cycles, 16);
    check({tag, "_hi"}, result_hi, exp_hi);
    check({tag, "_lo"}, result, exp_lo);
    check({tag, "_zero"}, zero, exp_zero);
    check({tag, "_carry"}, carry, 1'b0);
    tick();
    check({tag, "_done_drop"}, done, 1'b0);
  endtask

  initial begin
    logic saw_done;
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; signal = 2'b00; a = '0; b = '0;

    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_result", result, 16'h0000);
    check("rst_hi", result_hi, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    tick();
    check("idle_done", done, 1'b0);
    check("idle_zero", zero, 1'b1);

    // ADD overflow
    start = 1'b1; signal = 2'b00; a = 16'hFFFF; b = 16'h0001;
    tick();
    start = 1'b0;
    check("add_done", done, 1'b1);
    check("add_result", result, 16'h0000);
    check("add_carry", carry, 1'b1);
    check("add_zero", zero, 1'b1);
    check("add_hi", result_hi, 16'h0000);
    tick();
    check("add_done_drop", done, 1'b0);
    check("add_hold_result", result, 16'h0000);
    check("add_hold_carry", carry, 1'b1);

    // AND then back-to-back OR
    start = 1'b1; signal = 2'b10; a = 16'hF0F0; b = 16'h3C3C;
    tick();
    check("and_done", done, 1'b1);
    check("and_result", result, 16'h3030);
    check("and_carry", carry, 1'b0);
    check("and_zero", zero, 1'b0);
    signal = 2'b11;
    tick();
    start = 1'b0;
    check("or_done", done, 1'b1);
    check("or_result", result, 16'hFCFC);
    tick();
    check("or_done_drop", done, 1'b0);

    // MUL timing, operand independence after acceptance, ignored starts
    start = 1'b1; signal = 2'b01; a = 16'h1234; b = 16'h0100;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; signal = 2'b00;
    for (int i = 0; i < 16; i++) begin
      check("mul_busy", busy, 1'b1);
      check("mul_nodone", done, 1'b0);
      start = (i == 3 || i == 7 || i == 15) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    check("mul_done", done, 1'b1);
    check("mul_busy_drop", busy, 1'b0);
    check("mul_hi", result_hi, 16'h0012);
    check("mul_lo", result, 16'h3400);
    check("mul_zero", zero, 1'b0);
    tick();
    check("mul_done_drop", done, 1'b0);
    check("mul_hold_lo", result, 16'h3400);

    run_mul("mul_max", 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    run_mul("mul_zero", 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b1);

    // Reset in the middle of a multiply
    start = 1'b1; signal = 2'b01; a = 16'h0005; b = 16'h0007;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_result", result, 16'h0000);
    check("mrst_hi", result_hi, 16'h0000);
    check("mrst_carry", carry, 1'b0);
    check("mrst_zero", zero, 1'b1);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("mrst_quiet", saw_done, 1'b0);

    start = 1'b1; signal = 2'b00; a = 16'h0002; b = 16'h0003;
    tick();
    start = 1'b0;
    check("post_add_done", done, 1'b1);
    check("post_add_result", result, 16'h0005);
    check("post_add_zero", zero, 1'b0);
    check("post_add_carry", carry, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
